reg_scoreboard: RTL and testbench

- Issue-hazard scheduler for the ID stage.
- Tracks which architectural registers have a write in flight, using the read and write enables/addresses produced by the ID-stage register-address decoder.
- Holds an instruction in ID (stall) until its source and destination registers are free.
- Sits between the ID decode logic and the ID/EX pipeline register. Its issue output gates the ID/EX advance.

---
 rtl/reg_scoreboard.sv | 158 +++++++++++++++
 tb/tb_reg_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: tracks in-flight writes per architectural register
// and holds the decoded instruction until its sources and destination are free.
module reg_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LAT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [LAT_WIDTH-1:0]  write_lat,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  stall,
  output logic                  stall_raw,
  output logic                  stall_waw,
  output logic                  issue,
  output logic [ADDR_WIDTH:0]   busy_count
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_TIMED   = 2'd1,
    ST_WAIT_WB = 2'd2
  } entry_state_e;

  localparam logic [LAT_WIDTH-1:0]  LAT_ZERO  = {LAT_WIDTH{1'b0}};
  localparam logic [LAT_WIDTH-1:0]  LAT_ONE   = {{(LAT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH:0]   BUSY_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  entry_state_e           st_q  [REG_COUNT];
  entry_state_e           st_d  [REG_COUNT];
  logic [LAT_WIDTH-1:0]   cnt_q [REG_COUNT];
  logic [LAT_WIDTH-1:0]   cnt_d [REG_COUNT];

  logic                   src1_busy_s;
  logic                   src2_busy_s;
  logic                   dst_busy_s;
  logic                   issue_s;
  logic                   alloc_s;
  logic [ADDR_WIDTH:0]    busy_s;

  // Hazard lookup against the registered entry states
  always_comb begin
    src1_busy_s = 1'b0;
    src2_busy_s = 1'b0;
    dst_busy_s  = 1'b0;
    if (read_en_1 && (read_addr_1 != ADDR_ZERO)) begin
      src1_busy_s = (st_q[read_addr_1] != ST_FREE);
    end else begin
      src1_busy_s = 1'b0;
    end
    if (read_en_2 && (read_addr_2 != ADDR_ZERO)) begin
      src2_busy_s = (st_q[read_addr_2] != ST_FREE);
    end else begin
      src2_busy_s = 1'b0;
    end
    if (write_en && (write_addr != ADDR_ZERO)) begin
      dst_busy_s = (st_q[write_addr] != ST_FREE);
    end else begin
      dst_busy_s = 1'b0;
    end
  end

  assign stall_raw  = id_valid & (src1_busy_s | src2_busy_s);
  assign stall_waw  = id_valid & dst_busy_s;
  assign stall      = stall_raw | stall_waw;
  assign issue_s    = rst & id_valid & ~stall & ~flush;
  assign issue      = issue_s;
  assign alloc_s    = issue_s & write_en & (write_addr != ADDR_ZERO);
  assign busy_count = busy_s;

  // Per-entry next state. A timed write loads lat-1 so the entry frees on the
  // edge that ends cycle lat-1 and a consumer issues exactly lat cycles later;
  // lat=1 is forwardable next cycle and needs no entry at all.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      st_d[r]  = st_q[r];
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        st_d[r]  = ST_FREE;
        cnt_d[r] = LAT_ZERO;
      end else begin
        case (st_q[r])
          ST_TIMED: begin
            if (flush || (cnt_q[r] == LAT_ONE)) begin
              st_d[r]  = ST_FREE;
              cnt_d[r] = LAT_ZERO;
            end else begin
              cnt_d[r] = cnt_q[r] - LAT_ONE;
            end
          end
          ST_WAIT_WB: begin
            if (wb_en && (wb_addr == ADDR_WIDTH'(r))) begin
              st_d[r] = ST_FREE;
            end else begin
              st_d[r] = ST_WAIT_WB;
            end
          end
          ST_FREE: begin
            if (alloc_s && (write_addr == ADDR_WIDTH'(r))) begin
              if (write_lat == LAT_ZERO) begin
                st_d[r] = ST_WAIT_WB;
              end else if (write_lat == LAT_ONE) begin
                st_d[r] = ST_FREE;
              end else begin
                st_d[r]  = ST_TIMED;
                cnt_d[r] = write_lat - LAT_ONE;
              end
            end else begin
              st_d[r] = ST_FREE;
            end
          end
          default: begin
            st_d[r]  = ST_FREE;
            cnt_d[r] = LAT_ZERO;
          end
        endcase
      end
    end
  end

  // Occupancy count of the registered state
  always_comb begin
    busy_s = {(ADDR_WIDTH+1){1'b0}};
    for (int r = 1; r < REG_COUNT; r++) begin
      if (st_q[r] != ST_FREE) begin
        busy_s = busy_s + BUSY_ONE;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Entry state registers; reset drops every pending write, WAIT_WB included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        st_q[r]  <= ST_FREE;
        cnt_q[r] <= LAT_ZERO;
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        st_q[r]  <= st_d[r];
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-cycle vector table plus hand-written
// sequences for unknown-latency writeback and reset during a countdown.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush, id_valid, read_en_1, read_en_2, write_en, wb_en;
  logic [4:0] read_addr_1, read_addr_2, write_addr, wb_addr;
  logic [2:0] write_lat;
  logic       stall, stall_raw, stall_waw, issue;
  logic [5:0] busy_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst, idv, re1;
    logic [4:0] ra1;
    logic       re2;
    logic [4:0] ra2;
    logic       we;
    logic [4:0] wa;
    logic [2:0] lat;
    logic       wb;
    logic [4:0] wba;
    logic       fl;
    logic       e_stall, e_raw, e_waw, e_issue;
    logic [5:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  reg_scoreboard #(.REG_COUNT(32), .ADDR_WIDTH(5), .LAT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2),
    .write_en(write_en), .write_addr(write_addr), .write_lat(write_lat),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw),
    .issue(issue), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic idv,
                              input logic re1, input int ra1, input logic re2, input int ra2,
                              input logic we, input int wa, input int lat,
                              input logic wb, input int wba, input logic fl,
                              input logic es, input logic er, input logic ew,
                              input logic ei, input int eb);
    vec_t v;
    v.rst = r; v.idv = idv; v.re1 = re1; v.ra1 = 5'(ra1); v.re2 = re2; v.ra2 = 5'(ra2);
    v.we = we; v.wa = 5'(wa); v.lat = 3'(lat); v.wb = wb; v.wba = 5'(wba); v.fl = fl;
    v.e_stall = es; v.e_raw = er; v.e_waw = ew; v.e_issue = ei; v.e_busy = 6'(eb);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic es, input logic er,
                         input logic ew, input logic ei, input logic [5:0] eb);
    chk({tag, ".stall"}, idx, {5'd0, stall}, {5'd0, es});
    chk({tag, ".stall_raw"}, idx, {5'd0, stall_raw}, {5'd0, er});
    chk({tag, ".stall_waw"}, idx, {5'd0, stall_waw}, {5'd0, ew});
    chk({tag, ".issue"}, idx, {5'd0, issue}, {5'd0, ei});
    chk({tag, ".busy_count"}, idx, busy_count, eb);
  endtask

  task automatic idle();
    flush = 1'b0; id_valid = 1'b0; read_en_1 = 1'b0; read_addr_1 = 5'd0;
    read_en_2 = 1'b0; read_addr_2 = 5'd0; write_en = 1'b0; write_addr = 5'd0;
    write_lat = 3'd0; wb_en = 1'b0; wb_addr = 5'd0;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; id_valid = v.idv; read_en_1 = v.re1; read_addr_1 = v.ra1;
    read_en_2 = v.re2; read_addr_2 = v.ra2; write_en = v.we; write_addr = v.wa;
    write_lat = v.lat; wb_en = v.wb; wb_addr = v.wba; flush = v.fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // rst idv re1 ra1 re2 ra2 we wa lat wb wba fl | stall raw waw issue busy
    tbl.push_back(mk(0,1, 1,5, 0,0, 0,0,0, 0,0, 0,  0,0,0,0, 0)); // in reset
    tbl.push_back(mk(1,1, 1,5, 0,0, 1,5,2, 0,0, 0,  0,0,0,1, 0));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 0,  0,0,0,0, 1));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 0,  0,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0, 0,0, 1,8,2, 0,0, 0,  0,0,0,1, 0)); // timed RAW producer
    tbl.push_back(mk(1,1, 1,8, 0,0, 0,0,0, 0,0, 0,  1,1,0,0, 1));
    tbl.push_back(mk(1,1, 1,8, 0,0, 0,0,0, 0,0, 0,  0,0,0,1, 0));
    tbl.push_back(mk(1,1, 0,0, 0,0, 1,4,0, 0,0, 0,  0,0,0,1, 0)); // r4 WAIT_WB
    tbl.push_back(mk(1,1, 1,9, 0,0, 1,4,3, 0,0, 0,  1,0,1,0, 1)); // WAW on r4
    tbl.push_back(mk(1,1, 1,0, 1,0, 1,0,0, 0,0, 0,  0,0,0,1, 1)); // write r0
    tbl.push_back(mk(1,1, 1,0, 0,0, 0,0,0, 1,0, 0,  0,0,0,1, 1)); // wb r0 ignored
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 1,4, 0,  0,0,0,0, 1));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 0,  0,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0, 0,0, 1,7,0, 0,0, 0,  0,0,0,1, 0)); // r7 WAIT_WB
    tbl.push_back(mk(1,1, 0,0, 0,0, 1,6,4, 0,0, 0,  0,0,0,1, 1)); // r6 TIMED cnt 3
    tbl.push_back(mk(1,1, 1,1, 0,0, 1,9,0, 0,0, 1,  0,0,0,0, 2)); // flush
    tbl.push_back(mk(1,1, 1,6, 0,0, 0,0,0, 0,0, 0,  0,0,0,1, 1));
    tbl.push_back(mk(1,1, 1,7, 0,0, 0,0,0, 0,0, 0,  1,1,0,0, 1));
    tbl.push_back(mk(1,1, 1,9, 0,0, 0,0,0, 0,0, 0,  0,0,0,1, 1)); // r9 never created
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 1,7, 1,  0,0,0,0, 1)); // flush + wb r7
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 0,  0,0,0,0, 0));
    tbl.push_back(mk(1,1, 0,0, 0,0, 1,10,3, 0,0, 0, 0,0,0,1, 0)); // r10 TIMED cnt 2
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 1,10, 0, 0,0,0,0, 1)); // wb to TIMED ignored
    tbl.push_back(mk(1,1, 1,10, 0,0, 0,0,0, 0,0, 0, 1,1,0,0, 1));
    tbl.push_back(mk(1,1, 1,10, 0,0, 0,0,0, 0,0, 0, 0,0,0,1, 0));

    next_cycle();
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #3;
      chk_all("tbl", i, tbl[i].e_stall, tbl[i].e_raw, tbl[i].e_waw, tbl[i].e_issue, tbl[i].e_busy);
      next_cycle();
    end

    // Unknown-latency producer on r3, writeback in cycle 10, consumer issues in 11
    idle(); rst = 1'b1;
    id_valid = 1'b1; write_en = 1'b1; write_addr = 5'd3; write_lat = 3'd0;
    #3; chk_all("div", 0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    next_cycle();
    for (int c = 1; c <= 10; c++) begin
      idle();
      id_valid = 1'b1; read_en_2 = 1'b1; read_addr_2 = 5'd3;
      wb_en = (c == 10); wb_addr = 5'd3;
      #3; chk_all("div", c, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
      next_cycle();
    end
    idle();
    id_valid = 1'b1; read_en_2 = 1'b1; read_addr_2 = 5'd3;
    #3; chk_all("div", 11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    next_cycle();

    // Reset asserted mid-countdown drops TIMED and WAIT_WB entries at once
    idle();
    id_valid = 1'b1; write_en = 1'b1; write_addr = 5'd12; write_lat = 3'd0;
    #3; chk_all("rstseq", 0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    next_cycle();
    idle();
    id_valid = 1'b1; write_en = 1'b1; write_addr = 5'd11; write_lat = 3'd5;
    #3; chk_all("rstseq", 1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1);
    next_cycle();
    idle();
    id_valid = 1'b1; read_en_1 = 1'b1; read_addr_1 = 5'd11;
    write_en = 1'b1; write_addr = 5'd12; write_lat = 3'd2;
    #2; chk_all("rstseq", 2, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2);
    rst = 1'b0;
    #1; chk_all("rstseq", 3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    next_cycle();
    rst = 1'b1;
    idle();
    id_valid = 1'b1; read_en_1 = 1'b1; read_addr_1 = 5'd11;
    read_en_2 = 1'b1; read_addr_2 = 5'd12;
    #3; chk_all("rstseq", 4, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
